jk_register_bank: RTL and testbench
===================================

// Module: jk_register_bank
// PURPOSE
//   Parametrised bank of WIDTH JK flip-flops on one shared negative-edge clock CP
//     and one shared asynchronous active-low reset R.
//   Successor to the fixed dual JK part. Adds a per-bank mode select:
//     - independent JK
//     - synchronous binary up-counter
//     - serial shift register
//     - parallel load
//   Used as the generic register/counter primitive for larger chip models.
// PARAMETERS
//   WIDTH      4   number of flip-flops (>=1)
//   RESET_VAL  0   WIDTH-bit value forced onto Q while R is low
// PORTS
//   CP    in   1      clock; all state changes on falling edge
//   R     in   1      asynchronous reset, active-low
//   MODE  in   2      00 JK, 01 COUNT, 10 SHIFT, 11 LOAD
//   EN    in   1      enable for COUNT and SHIFT; ignored in JK and LOAD
//   J     in   WIDTH  per-bit J input (JK mode)
//   K     in   WIDTH  per-bit K input (JK mode)
//   D     in   WIDTH  parallel load data (LOAD mode)
//   SI    in   1      serial input, shifted into Q[0] (SHIFT mode)
//   Q     out  WIDTH  register state
//   nQ    out  WIDTH  always ~Q, including during reset
//   TC    out  1      terminal count, combinational: MODE==COUNT & EN & (&Q)
//   SO    out  1      serial output = Q[WIDTH-1]
// BEHAVIOUR
//   Reset
//     - R low: Q=RESET_VAL, nQ=~RESET_VAL immediately, no clock needed.
//     - CP edges are ignored while R is low.
//     - First falling CP edge after R rises acts normally.
//   Latency: one falling edge from inputs to Q. MODE, EN and data are sampled at
//     that same edge. A mode change takes effect on the next edge; no state is lost.
//   JK mode, per bit i, independently:
//     - J=0 K=0: hold
//     - J=0 K=1: Q=0
//     - J=1 K=0: Q=1
//     - J=1 K=1: toggle
//   COUNT mode
//     - EN=1: Q <= Q+1 mod 2^WIDTH. All-ones wraps to 0 with no extra state.
//     - EN=0: hold.
//   SHIFT mode
//     - EN=1: Q <= {Q[WIDTH-2:0], SI}.
//     - WIDTH=1: Q <= SI.
//     - EN=0: hold.
//   LOAD mode: Q <= D on every edge, regardless of EN.
//   TC
//     - High only in COUNT with EN=1 and Q all ones, i.e. the edge that wraps.
//     - Forced 0 during reset unless RESET_VAL is all ones; it follows the formula.
//   Simultaneous events: reset dominates any clock edge. X on MODE is undefined;
//     the bench must not drive it.
// STRUCTURE
//   Shared package (jk_bank_pkg)
//     - MODE_JK=2'b00, MODE_COUNT=2'b01, MODE_SHIFT=2'b10, MODE_LOAD=2'b11
//     - typedef jk_mode_t as a 2-bit enum
//   Sub-module jk_cell: one negedge JK flip-flop with async active-low reset and
//     per-instance reset value. The bank instantiates WIDTH cells.
//   Per-bit J/K steering, by mode:
//     - JK:    J[i], K[i]
//     - COUNT: J=K=EN & (&Q[i-1:0]); bit 0 uses EN
//     - SHIFT: src=(i==0 ? SI : Q[i-1]); J=EN&src, K=EN&~src
//     - LOAD:  J=D[i], K=~D[i]
// TESTING (WIDTH=4, RESET_VAL=0 unless stated)
//   1. R=0 mid-stream with Q=4'b1011 -> Q=0000 and nQ=1111 before the next CP edge.
//      Edges while R=0 leave Q=0.
//   2. JK mode, J=4'b1100, K=4'b1010, Q=4'b0110 -> one edge -> Q=4'b1100
//      (toggle, set, reset, hold).
//   3. COUNT, EN=1 from 0 -> 15 edges give Q=15 and TC=1 -> next edge Q=0, TC=0.
//      EN=0 for 3 edges holds the count.
//   4. SHIFT, EN=1, SI sequence 1,0,1,1 -> Q=4'b1011. SO follows Q[3] each edge.
//   5. LOAD D=4'h9 with EN=0 -> Q=9. Switch to COUNT, EN=1 -> Q=A on the next edge.
//   6. RESET_VAL=4'h5: release R, then LOAD D=0 -> Q=5 until the first edge, then 0.
//      Assert R coincident with a falling CP -> Q=5.

Source files
------------

// File: rtl/jk_register_bank_pkg.sv
// Shared mode encoding for the JK register bank and its bus interface.
package jk_bank_pkg;

  localparam logic [1:0] MODE_JK_C    = 2'b00;
  localparam logic [1:0] MODE_COUNT_C = 2'b01;
  localparam logic [1:0] MODE_SHIFT_C = 2'b10;
  localparam logic [1:0] MODE_LOAD_C  = 2'b11;

  typedef enum logic [1:0] {
    MODE_JK    = MODE_JK_C,
    MODE_COUNT = MODE_COUNT_C,
    MODE_SHIFT = MODE_SHIFT_C,
    MODE_LOAD  = MODE_LOAD_C
  } jk_mode_t;

endpackage

// File: rtl/jk_register_bank_if.sv
// Control/data bundle of the JK register bank; CP and R stay as plain ports.
interface jk_register_bank_if
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 4
);

  jk_mode_t           MODE;
  logic               EN;
  logic [WIDTH-1:0]   J;
  logic [WIDTH-1:0]   K;
  logic [WIDTH-1:0]   D;
  logic               SI;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   nQ;
  logic               TC;
  logic               SO;

  modport master (
    output MODE, EN, J, K, D, SI,
    input  Q, nQ, TC, SO
  );

  modport slave (
    input  MODE, EN, J, K, D, SI,
    output Q, nQ, TC, SO
  );

endinterface

// File: rtl/jk_register_bank_cell.sv
// Single falling-edge JK flip-flop with asynchronous active-low reset to a
// per-instance value.
module jk_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CP,
  input  logic R,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j_i, k_i})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(negedge CP or negedge R) begin
    if (!R) q_q <= RST_VAL;
    else    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK cells whose J/K inputs are steered by MODE to act as
// independent JK flops, a binary up-counter, a shift register or a parallel load.
module jk_register_bank
  import jk_bank_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               CP,
  input  logic               R,
  jk_register_bank_if.slave  bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] cnt_t;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH:0]   shift_cat;

  // Counter toggle enables form a ripple-AND chain seeded by EN.
  always_comb begin
    logic run;
    cnt_t = '0;
    run   = bus.EN;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_t[i] = run;
      run      = run & q[i];
    end
  end

  // Bit i shifts in from bit i-1; bit 0 takes SI. Works for WIDTH=1 too.
  assign shift_cat = {q, bus.SI};
  assign shift_src = shift_cat[WIDTH-1:0];

  always_comb begin
    j_s = '0;
    k_s = '0;
    case (bus.MODE)
      MODE_JK: begin
        j_s = bus.J;
        k_s = bus.K;
      end
      MODE_COUNT: begin
        j_s = cnt_t;
        k_s = cnt_t;
      end
      MODE_SHIFT: begin
        j_s = {WIDTH{bus.EN}} & shift_src;
        k_s = {WIDTH{bus.EN}} & ~shift_src;
      end
      MODE_LOAD: begin
        j_s = bus.D;
        k_s = ~bus.D;
      end
      default: begin
        j_s = '0;
        k_s = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .CP  (CP),
      .R   (R),
      .j_i (j_s[i]),
      .k_i (k_s[i]),
      .q_o (q[i])
    );
  end

  assign bus.Q  = q;
  assign bus.nQ = ~q;
  assign bus.TC = (bus.MODE == MODE_COUNT) & bus.EN & (&q);
  assign bus.SO = q[WIDTH-1];

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed self-checking bench: one bank with RESET_VAL=0 and one with RESET_VAL=5.
module tb_jk_register_bank;
  import jk_bank_pkg::*;

  logic CP;
  logic R;
  logic R5;
  int   n_checks;
  int   n_fail;

  jk_register_bank_if #(.WIDTH(4)) bus  ();
  jk_register_bank_if #(.WIDTH(4)) bus5 ();

  jk_register_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .CP  (CP),
    .R   (R),
    .bus (bus)
  );

  jk_register_bank #(.WIDTH(4), .RESET_VAL(4'h5)) dut5 (
    .CP  (CP),
    .R   (R5),
    .bus (bus5)
  );

  initial begin
    CP = 1'b1;
    forever #5 CP = ~CP;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge CP);
    #1;
  endtask

  task automatic test_reset();
    bus.MODE = MODE_LOAD; bus.EN = 1'b0; bus.D = 4'hF;
    #1;
    n_checks++; if (bus.Q !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", bus.Q); end
    n_checks++; if (bus.nQ !== 4'hF) begin n_fail++; $display("FAIL reset_nq: got %h want f", bus.nQ); end
    n_checks++; if (bus.TC !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", bus.TC); end
    n_checks++; if (bus.SO !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b want 0", bus.SO); end
    tick();
    n_checks++; if (bus.Q !== 4'h0) begin n_fail++; $display("FAIL reset_edge_ignored: got %h want 0", bus.Q); end
    @(posedge CP); R = 1'b1; bus.D = 4'hB;
    tick();
    n_checks++; if (bus.Q !== 4'hB) begin n_fail++; $display("FAIL reset_preload: got %h want b", bus.Q); end
    #2; R = 1'b0; bus.D = 4'hF;
    #1;
    n_checks++; if (bus.Q !== 4'h0) begin n_fail++; $display("FAIL reset_async_q: got %h want 0", bus.Q); end
    n_checks++; if (bus.nQ !== 4'hF) begin n_fail++; $display("FAIL reset_async_nq: got %h want f", bus.nQ); end
    tick();
    tick();
    n_checks++; if (bus.Q !== 4'h0) begin n_fail++; $display("FAIL reset_held: got %h want 0", bus.Q); end
    @(posedge CP); R = 1'b1; bus.D = 4'h3;
    tick();
    n_checks++; if (bus.Q !== 4'h3) begin n_fail++; $display("FAIL reset_first_edge: got %h want 3", bus.Q); end
  endtask

  task automatic test_jk();
    @(posedge CP); bus.MODE = MODE_LOAD; bus.D = 4'b0110;
    tick();
    n_checks++; if (bus.Q !== 4'b0110) begin n_fail++; $display("FAIL jk_preload: got %b want 0110", bus.Q); end
    bus.MODE = MODE_JK; bus.J = 4'b1100; bus.K = 4'b1010;
    tick();
    n_checks++; if (bus.Q !== 4'b1100) begin n_fail++; $display("FAIL jk_mix: got %b want 1100", bus.Q); end
    n_checks++; if (bus.nQ !== 4'b0011) begin n_fail++; $display("FAIL jk_mix_nq: got %b want 0011", bus.nQ); end
    bus.J = 4'b0000; bus.K = 4'b0000;
    tick();
    n_checks++; if (bus.Q !== 4'b1100) begin n_fail++; $display("FAIL jk_hold: got %b want 1100", bus.Q); end
    bus.J = 4'b1111; bus.K = 4'b1111;
    tick();
    n_checks++; if (bus.Q !== 4'b0011) begin n_fail++; $display("FAIL jk_toggle_all: got %b want 0011", bus.Q); end
  endtask

  task automatic test_count();
    logic [3:0] exp_q;
    bus.MODE = MODE_LOAD; bus.D = 4'h0;
    tick();
    bus.MODE = MODE_COUNT; bus.EN = 1'b1;
    exp_q = 4'h0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_q = exp_q + 4'h1;
      n_checks++; if (bus.Q !== exp_q) begin n_fail++; $display("FAIL count_step%0d: got %h want %h", i, bus.Q, exp_q); end
      if (i < 15) begin
        n_checks++; if (bus.TC !== 1'b0) begin n_fail++; $display("FAIL count_tc_low%0d: got %b want 0", i, bus.TC); end
      end
    end
    n_checks++; if (bus.TC !== 1'b1) begin n_fail++; $display("FAIL count_tc_high: got %b want 1", bus.TC); end
    bus.EN = 1'b0;
    #1;
    n_checks++; if (bus.TC !== 1'b0) begin n_fail++; $display("FAIL count_tc_en_low: got %b want 0", bus.TC); end
    bus.EN = 1'b1;
    tick();
    n_checks++; if (bus.Q !== 4'h0) begin n_fail++; $display("FAIL count_wrap: got %h want 0", bus.Q); end
    n_checks++; if (bus.TC !== 1'b0) begin n_fail++; $display("FAIL count_wrap_tc: got %b want 0", bus.TC); end
    tick();
    tick();
    n_checks++; if (bus.Q !== 4'h2) begin n_fail++; $display("FAIL count_after_wrap: got %h want 2", bus.Q); end
    bus.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.Q !== 4'h2) begin n_fail++; $display("FAIL count_hold%0d: got %h want 2", i, bus.Q); end
    end
  endtask

  task automatic test_shift();
    logic [3:0] si_seq;
    logic [3:0] exp_q [4];
    si_seq = 4'b1101;
    exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0101; exp_q[3] = 4'b1011;
    bus.MODE = MODE_LOAD; bus.D = 4'h0;
    tick();
    bus.MODE = MODE_SHIFT; bus.EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.SI = si_seq[i];
      tick();
      n_checks++; if (bus.Q !== exp_q[i]) begin n_fail++; $display("FAIL shift_q%0d: got %b want %b", i, bus.Q, exp_q[i]); end
      n_checks++; if (bus.SO !== exp_q[i][3]) begin n_fail++; $display("FAIL shift_so%0d: got %b want %b", i, bus.SO, exp_q[i][3]); end
    end
    bus.EN = 1'b0; bus.SI = 1'b0;
    tick();
    n_checks++; if (bus.Q !== 4'b1011) begin n_fail++; $display("FAIL shift_hold: got %b want 1011", bus.Q); end
    bus.EN = 1'b1;
    tick();
    n_checks++; if (bus.Q !== 4'b0110) begin n_fail++; $display("FAIL shift_out: got %b want 0110", bus.Q); end
    n_checks++; if (bus.TC !== 1'b0) begin n_fail++; $display("FAIL shift_tc: got %b want 0", bus.TC); end
  endtask

  task automatic test_load_count();
    bus.MODE = MODE_LOAD; bus.EN = 1'b0; bus.D = 4'h9;
    tick();
    n_checks++; if (bus.Q !== 4'h9) begin n_fail++; $display("FAIL load_q: got %h want 9", bus.Q); end
    bus.MODE = MODE_COUNT; bus.EN = 1'b1;
    tick();
    n_checks++; if (bus.Q !== 4'hA) begin n_fail++; $display("FAIL load_then_count: got %h want a", bus.Q); end
    bus.MODE = MODE_LOAD; bus.EN = 1'b1; bus.D = 4'hF;
    tick();
    n_checks++; if (bus.Q !== 4'hF) begin n_fail++; $display("FAIL load_en_high: got %h want f", bus.Q); end
    n_checks++; if (bus.TC !== 1'b0) begin n_fail++; $display("FAIL load_tc: got %b want 0", bus.TC); end
  endtask

  task automatic test_reset_val();
    n_checks++; if (bus5.Q !== 4'h5) begin n_fail++; $display("FAIL rv_reset_q: got %h want 5", bus5.Q); end
    n_checks++; if (bus5.nQ !== 4'hA) begin n_fail++; $display("FAIL rv_reset_nq: got %h want a", bus5.nQ); end
    n_checks++; if (bus5.TC !== 1'b0) begin n_fail++; $display("FAIL rv_reset_tc: got %b want 0", bus5.TC); end
    @(posedge CP); bus5.MODE = MODE_LOAD; bus5.D = 4'h0; R5 = 1'b1;
    #1;
    n_checks++; if (bus5.Q !== 4'h5) begin n_fail++; $display("FAIL rv_before_edge: got %h want 5", bus5.Q); end
    tick();
    n_checks++; if (bus5.Q !== 4'h0) begin n_fail++; $display("FAIL rv_first_edge: got %h want 0", bus5.Q); end
    bus5.D = 4'hF;
    @(negedge CP); R5 = 1'b0;
    #1;
    n_checks++; if (bus5.Q !== 4'h5) begin n_fail++; $display("FAIL rv_coincident: got %h want 5", bus5.Q); end
    n_checks++; if (bus5.nQ !== 4'hA) begin n_fail++; $display("FAIL rv_coincident_nq: got %h want a", bus5.nQ); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    R  = 1'b0;
    R5 = 1'b0;
    bus.MODE = MODE_LOAD; bus.EN = 1'b0; bus.J = '0; bus.K = '0; bus.D = '0; bus.SI = 1'b0;
    bus5.MODE = MODE_COUNT; bus5.EN = 1'b1; bus5.J = '0; bus5.K = '0; bus5.D = '0; bus5.SI = 1'b0;
    test_reset();
    test_jk();
    test_count();
    test_shift();
    test_load_count();
    test_reset_val();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
